// File: rtl/ws_systolic_array_p_if.sv
// +----------------------------------------------------------------------------+
// | ws_systolic_array_p_if : weight-write, A-stream, C-stream and status bundle |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ws_systolic_array_p_if #(
  parameter int N      = 10,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  localparam int ROW_W = $clog2(N);

  logic                  w_we;
  logic [ROW_W-1:0]      w_row;
  logic [N*DATA_W-1:0]   w_data;
  logic                  start;
  logic                  sat_en;
  logic                  a_valid;
  logic                  a_ready;
  logic [N*DATA_W-1:0]   a_data;
  logic                  c_valid;
  logic                  c_ready;
  logic [ROW_W-1:0]      c_row;
  logic [N*OUT_W-1:0]    c_data;
  logic                  busy;
  logic                  done;

  modport master (
    output w_we, w_row, w_data, start, sat_en, a_valid, a_data, c_ready,
    input  a_ready, c_valid, c_row, c_data, busy, done
  );

  modport slave (
    input  w_we, w_row, w_data, start, sat_en, a_valid, a_data, c_ready,
    output a_ready, c_valid, c_row, c_data, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ws_systolic_array_p.sv
// +----------------------------------------------------------------------------+
// | ws_systolic_array_p : weight-stationary NxN systolic multiplier C = A x W   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module ws_systolic_array_p #(
  parameter int N      = 10,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ws_systolic_array_p_if.slave  bus
);
  localparam int ROW_W = $clog2(N);
  localparam int CNT_W = $clog2(3*N);
  localparam int PRD_W = 2*DATA_W;
  localparam logic [CNT_W-1:0] c_last_row = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] c_last_cmp = CNT_W'(3*N-2);
  localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_A  = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sat;
  logic                     r_done;
  logic [DATA_W-1:0]        r_wt   [N][N];
  logic [DATA_W-1:0]        r_ab   [N][N];
  logic [DATA_W-1:0]        r_act  [N][N-1];
  logic [ACC_W-1:0]         r_psum [N][N];
  logic signed [ACC_W-1:0]  r_res  [N][N];
  logic [DATA_W-1:0]        w_act_in   [N][N];
  logic [ACC_W-1:0]         w_psum_in  [N][N];
  logic [PRD_W-1:0]         w_prod     [N][N];
  logic [ACC_W-1:0]         w_psum_nxt [N][N];
  logic signed [ACC_W-1:0]  w_row_sel  [N];
  logic [N*OUT_W-1:0]       w_c_data;
  logic                     w_a_hs;
  logic                     w_c_hs;

  assign w_a_hs = (r_state == S_LOAD_A) && bus.a_valid;
  assign w_c_hs = (r_state == S_OUTPUT) && bus.c_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start)                     w_state_nxt = S_LOAD_A;
      S_LOAD_A:  if (w_a_hs && r_cnt == c_last_row) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (r_cnt == c_last_cmp)           w_state_nxt = S_OUTPUT;
      S_OUTPUT:  if (w_c_hs && r_cnt == c_last_row) w_state_nxt = S_IDLE;
      default:                                      w_state_nxt = S_IDLE;
    endcase
  end

  // One counter serves A rows, compute cycles and C rows; it restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_c_hs && (r_cnt == c_last_row);
      if (r_state == S_IDLE && bus.start) r_sat <= bus.sat_en;
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (w_a_hs || w_c_hs || r_state == S_COMPUTE)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) begin
          r_wt[k][j] <= '0;
          r_ab[k][j] <= '0;
        end
    end else begin
      for (int k = 0; k < N; k++)
        if (r_state == S_IDLE && bus.w_we && bus.w_row == ROW_W'(k))
          for (int j = 0; j < N; j++) r_wt[k][j] <= bus.w_data[j*DATA_W +: DATA_W];
      for (int i = 0; i < N; i++)
        if (w_a_hs && r_cnt == CNT_W'(i))
          for (int k = 0; k < N; k++) r_ab[i][k] <= bus.a_data[k*DATA_W +: DATA_W];
    end
  end

  // Array row k sees A[i][k] at compute cycle i+k; zeros outside that window.
  always_comb begin
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        w_act_in[k][j]  = '0;
        w_psum_in[k][j] = '0;
      end
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (r_state == S_COMPUTE && r_cnt == CNT_W'(i+k)) w_act_in[k][0] = r_ab[i][k];
    for (int k = 0; k < N; k++)
      for (int j = 1; j < N; j++) w_act_in[k][j] = r_act[k][j-1];
    for (int k = 1; k < N; k++)
      for (int j = 0; j < N; j++) w_psum_in[k][j] = r_psum[k-1][j];
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        w_prod[k][j] = {{DATA_W{w_act_in[k][j][DATA_W-1]}}, w_act_in[k][j]} *
                       {{DATA_W{r_wt[k][j][DATA_W-1]}},     r_wt[k][j]};
        w_psum_nxt[k][j] = w_psum_in[k][j] +
                           {{(ACC_W-PRD_W){w_prod[k][j][PRD_W-1]}}, w_prod[k][j]};
      end
  end

  // Bottom psum of column j holds C[i][j] at compute cycle i+N+j.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) begin
          r_psum[k][j] <= '0;
          r_res[k][j]  <= '0;
          if (j < N-1) r_act[k][j] <= '0;
        end
    end else begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) begin
          r_psum[k][j] <= (r_state == S_COMPUTE) ? w_psum_nxt[k][j] : '0;
          if (j < N-1) r_act[k][j] <= (r_state == S_COMPUTE) ? w_act_in[k][j] : '0;
          if (r_state == S_COMPUTE && r_cnt == CNT_W'(k+N+j)) r_res[k][j] <= r_psum[N-1][j];
        end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) w_row_sel[j] = '0;
    for (int i = 0; i < N; i++)
      if (r_cnt == CNT_W'(i))
        for (int j = 0; j < N; j++) w_row_sel[j] = r_res[i][j];
    w_c_data = '0;
    if (r_state == S_OUTPUT)
      for (int j = 0; j < N; j++) begin
        if (r_sat && w_row_sel[j] > c_sat_max)
          w_c_data[j*OUT_W +: OUT_W] = c_sat_max[OUT_W-1:0];
        else if (r_sat && w_row_sel[j] < c_sat_min)
          w_c_data[j*OUT_W +: OUT_W] = c_sat_min[OUT_W-1:0];
        else
          w_c_data[j*OUT_W +: OUT_W] = w_row_sel[j][OUT_W-1:0];
      end
  end

  assign bus.a_ready = (r_state == S_LOAD_A);
  assign bus.c_valid = (r_state == S_OUTPUT);
  assign bus.c_row   = (r_state == S_OUTPUT) ? r_cnt[ROW_W-1:0] : '0;
  assign bus.c_data  = w_c_data;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ws_systolic_array_p.sv
// +----------------------------------------------------------------------------+
// | tb_ws_systolic_array_p : scoreboard bench with a plain matrix-product model |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ws_systolic_array_p;
  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ws_systolic_array_p_if #(.N(N), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

  ws_systolic_array_p #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]         row;
    logic [N*OUT_W-1:0] data;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   wm [N][N];
  int   am [N][N];
  exp_t sb [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer dot products, then clamp or keep the low 16 bits.
  function automatic logic [N*OUT_W-1:0] ref_row(input int i, input bit sat);
    logic [N*OUT_W-1:0] r;
    longint s, v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += longint'(am[i][k]) * longint'(wm[k][j]);
      v = s;
      if (sat) begin
        if (s > 32767)       v = 32767;
        else if (s < -32768) v = -32768;
      end
      r[j*OUT_W +: OUT_W] = v[15:0];
    end
    return r;
  endfunction

  exp_t       mon_e;
  logic       mon_last  = 1'b0;
  logic       mon_stall = 1'b0;
  logic [1:0] mon_row;
  logic [63:0] mon_data;

  always @(negedge clk) begin
    if (!rst) begin
      mon_last  = 1'b0;
      mon_stall = 1'b0;
    end else begin
      if (mon_last || bus.done) begin
        chk("done_pulse", 64'(bus.done), 64'(mon_last));
        if (mon_last) chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
      if (mon_stall) begin
        chk("hold_valid", 64'(bus.c_valid), 64'd1);
        chk("hold_row", 64'(bus.c_row), 64'(mon_row));
        chk("hold_data", 64'(bus.c_data), mon_data);
      end
      mon_last = 1'b0;
      if (bus.c_valid && bus.c_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_row actual=%0d required=none", bus.c_row);
        end else begin
          mon_e = sb.pop_front();
          chk("c_row", 64'(bus.c_row), 64'(mon_e.row));
          chk("c_data", 64'(bus.c_data), 64'(mon_e.data));
          mon_last = (mon_e.row == 2'(N-1));
        end
      end
      mon_stall = bus.c_valid && !bus.c_ready;
      mon_row   = bus.c_row;
      mon_data  = 64'(bus.c_data);
    end
  end

  task automatic load_w();
    for (int k = 0; k < N; k++) begin
      bus.w_we  = 1'b1;
      bus.w_row = 2'(k);
      for (int j = 0; j < N; j++) bus.w_data[j*DATA_W +: DATA_W] = 8'(wm[k][j]);
      tick();
    end
    bus.w_we = 1'b0;
  endtask

  task automatic set_w_identity();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) wm[k][j] = (k == j) ? 1 : 0;
  endtask

  task automatic set_a_test1();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        am[i][k] = (i == 0) ? k+1 : (i == 1) ? -(k+1) : (i == 2) ? k+5 : 0;
  endtask

  task automatic run_op(input bit sat, input bit gap_a, input int stall_row,
                        input bit rand_c, input bit wr_lock, input bit abort);
    int   idx, lat, guard, stalls;
    bit   hs, seen_valid;
    exp_t e;
    if (!abort)
      for (int i = 0; i < N; i++) begin
        e.row  = 2'(i);
        e.data = ref_row(i, sat);
        sb.push_back(e);
      end
    bus.sat_en = sat;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.sat_en = !sat;
    chk("busy_after_start", 64'(bus.busy), 64'd1);

    idx = 0;
    guard = 0;
    while (idx < N && guard < 200) begin
      bus.a_valid = gap_a ? (guard % 2 == 0) : 1'b1;
      if (bus.a_valid)
        for (int k = 0; k < N; k++) bus.a_data[k*DATA_W +: DATA_W] = 8'(am[idx][k]);
      else
        bus.a_data = 32'($urandom);
      hs = bus.a_valid && bus.a_ready;
      tick();
      guard++;
      if (hs) idx++;
    end
    bus.a_valid = 1'b0;
    chk("a_rows_accepted", 64'(idx), 64'(N));
    chk("a_ready_drop", 64'(bus.a_ready), 64'd0);

    lat = 0;
    while (!bus.c_valid && lat < 60) begin
      if (wr_lock && lat >= 1 && lat <= N) begin
        bus.w_we   = 1'b1;
        bus.w_row  = 2'(lat-1);
        bus.w_data = '0;
      end else begin
        bus.w_we = 1'b0;
      end
      if (abort && lat == 3) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_c_valid", 64'(bus.c_valid), 64'd0);
        chk("abort_a_ready", 64'(bus.a_ready), 64'd0);
        tick();
        rst = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
          tick();
          if (bus.c_valid || bus.busy) seen_valid = 1'b1;
        end
        chk("abort_stays_idle", 64'(seen_valid), 64'd0);
        for (int k = 0; k < N; k++)
          for (int j = 0; j < N; j++) wm[k][j] = 0;
        return;
      end
      tick();
      lat++;
    end
    bus.w_we = 1'b0;
    chk("compute_latency", 64'(lat), 64'(3*N-1));

    guard = 0;
    stalls = 0;
    while (bus.c_valid && guard < 200) begin
      if (int'(bus.c_row) == stall_row && stalls < 5) begin
        bus.c_ready = 1'b0;
        stalls++;
      end else begin
        bus.c_ready = rand_c ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      tick();
      guard++;
    end
    bus.c_ready = 1'b0;
    chk("output_drained", 64'(bus.c_valid), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    bus.w_we    = 1'b0;
    bus.w_row   = '0;
    bus.w_data  = '0;
    bus.start   = 1'b0;
    bus.sat_en  = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.c_ready = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_c_valid", 64'(bus.c_valid), 64'd0);
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_c_data", 64'(bus.c_data), 64'd0);
    chk("rst_c_row", 64'(bus.c_row), 64'd0);
    rst = 1'b1;
    tick();

    set_w_identity();
    load_w();
    set_a_test1();
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        wm[k][j] = 127;
        am[k][j] = 127;
      end
    load_w();
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) am[i][k] = -128;
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    set_w_identity();
    load_w();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) am[i][k] = int'($urandom_range(0, 255)) - 128;
    run_op(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);

    set_a_test1();
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    set_w_identity();
    load_w();
    set_a_test1();
    run_op(1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          wm[i][k] = int'($urandom_range(0, 255)) - 128;
          am[i][k] = int'($urandom_range(0, 255)) - 128;
        end
      load_w();
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b1, 1'b0, 1'b0);
    end

    repeat (3) tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

endmodule

`default_nettype wire

// File: doc/ws_systolic_array_p.md
Name: ws_systolic_array_p

Overview:
- Parametrised weight-stationary systolic matrix multiplier. Computes C = A x W for N x N signed matrices.
- Weights are loaded through a row-write port. A rows arrive over a valid/ready stream. C rows leave over a valid/ready stream with backpressure.
- Adds a runtime saturate/wrap output mode and a busy/done handshake. Sits between the NPU input buffer and the result writeback path.

Parameters:
- N, 10, array dimension (rows = columns = reduction depth); legal range 2..16
- DATA_W, 16, signed width of A and W elements
- ACC_W, 40, signed accumulator width inside the array; must be >= 2*DATA_W + clog2(N)
- OUT_W, 16, signed width of each emitted C element

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- w_we  in  1  weight row write strobe
- w_row  in  clog2(N)  weight row index k
- w_data  in  N*DATA_W  W[k][j] at bits [j*DATA_W +: DATA_W]
- start  in  1  begin operation (sampled in IDLE only)
- sat_en  in  1  output mode: 1 = saturate, 0 = wrap; latched on start
- a_valid  in  1  A row valid
- a_ready  out  1  block accepts an A row
- a_data  in  N*DATA_W  A[i][k] at bits [k*DATA_W +: DATA_W]; rows arrive in order i = 0..N-1
- c_valid  out  1  C row valid
- c_ready  in  1  consumer accepts a C row
- c_row  out  clog2(N)  index of the presented C row
- c_data  out  N*OUT_W  C[i][j] at bits [j*OUT_W +: OUT_W]
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse when the last C row is accepted

Behaviour:
- Reset (rst=0, async):
  - state = IDLE; all outputs 0; weight store, A buffer, accumulators and result buffer cleared to 0.
  - Reset asserted in any state aborts the operation; no done pulse is produced.
- States: IDLE -> LOAD_A -> COMPUTE -> OUTPUT -> IDLE.
- IDLE:
  - w_we=1 writes w_data to row w_row, visible to the next start.
  - start=1 latches sat_en and moves to LOAD_A next cycle.
  - If w_we and start are high in the same cycle, the write completes and is used by that operation.
- w_we outside IDLE: ignored, weight store unchanged.
- LOAD_A:
  - a_ready=1. Each a_valid & a_ready cycle stores one row into the A buffer and increments the row counter.
  - After N rows are accepted, go to COMPUTE; a_ready drops in the cycle after the Nth handshake.
  - a_valid gaps are allowed; the counter holds during gaps.
- COMPUTE:
  - Lasts exactly 3N-1 cycles (counter 0..3N-2); a_ready=0, c_valid=0.
  - Row i of the array receives column i of A skewed by i cycles; zeros are injected outside the valid window.
  - Each PE registers the activation passed right and the psum passed down.
  - Each psum is ACC_W wide and wraps modulo 2^ACC_W (no overflow within the legal parameter range).
  - Column outputs at the bottom row are captured into the result buffer at the cycles where each C row is complete.
  - After cycle 3N-2, go to OUTPUT.
- OUTPUT:
  - c_valid=1, c_row = r, c_data = converted row r, with r starting at 0.
  - The row advances only on c_valid & c_ready.
  - While c_ready=0, c_valid, c_row and c_data hold stable.
  - On the handshake of row N-1: done=1 for exactly that next cycle, state returns to IDLE, c_valid returns to 0.
- Output conversion per element, from an ACC_W value x:
  - sat_en=1: clamp x to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_en=0: take the low OUT_W bits (two's-complement wrap).
- start outside IDLE: ignored.
- busy=1 from the cycle after start is accepted until the cycle done pulses (inclusive); busy=0 while done is high.
- Weights persist across operations until rewritten or reset.

Test Plan:
- Bench configuration: N=4, DATA_W=8, ACC_W=24, OUT_W=16.
1. Identity: W = identity, A rows [1,2,3,4], [-1,-2,-3,-4], [5,6,7,8], [0,0,0,0], sat_en=1 -> C rows equal A rows, c_row 0..3, one done pulse, busy falls with done.
2. Saturation: all W=127, all A=127 (dot product 64516) -> sat_en=1 gives every element 32767; sat_en=0 gives every element -1020.
3. Negative saturation: all W=127, all A=-128 (dot product -65024) -> sat_en=1 gives -32768; sat_en=0 gives 512.
4. Handshake stress:
   - a_valid toggles 1/0 each cycle during LOAD_A -> exactly 4 rows accepted.
   - c_ready held 0 for 5 cycles on row 1 -> c_row=1 and c_data stable throughout; no row skipped or duplicated.
5. Write lockout: w_we with all-zero data during COMPUTE -> results unchanged from the identity case; the next operation still uses identity W.
6. Reset mid-COMPUTE: rst=0 for 1 cycle -> busy=0, c_valid=0, done never pulses. A following full run with reloaded identity W reproduces test 1 exactly.
